// File: rtl/gate_vector_checker.sv
// Exhaustive truth-table exerciser for a single N-input gate: sweeps every vector,
// compares the gate output after SETTLE cycles. Optional macro GVC_STOP_ON_ERR_EN.
module gate_vector_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   func,
  input  logic         dut_y,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state, state_nxt;
  logic [1:0] func_q;
  logic [3:0] cnt;
  logic       expected;
  logic       mismatch;
  logic       last_vec;
  logic       stop_now;

  always_comb begin
    unique case (func_q)
      2'b01:   expected = ~|vec;
      2'b10:   expected = ~vec[0];
      default: expected = ~&vec;
    endcase
  end

  assign mismatch = (dut_y != expected);
  assign last_vec = &vec;

`ifdef GVC_STOP_ON_ERR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_DRIVE;
      ST_DRIVE:  if (cnt == 4'd1) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (last_vec || stop_now) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: vector, settle counter, latched function and the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec           <= '0;
      cnt           <= '0;
      func_q        <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      pass          <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            vec           <= '0;
            cnt           <= SETTLE_CNT;
            func_q        <= func;
            err_count     <= '0;
            first_err_vec <= '0;
            pass          <= 1'b0;
          end
        end
        ST_DRIVE: cnt <= cnt - 1'b1;
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_vec <= vec;
          end
          if (last_vec || stop_now) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec <= vec + 1'b1;
            cnt <= SETTLE_CNT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: two instances (N=2/SETTLE=1, N=3/SETTLE=2)
// driven by fault-injecting gate models, checked cycle by cycle against a sweep model.
module tb_gate_vector_checker;
  localparam int NA = 2, SA = 1;
  localparam int NB = 3, SB = 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    func;
  logic          y_a, y_b;
  logic [NA-1:0] vec_a, fev_a;
  logic [NB-1:0] vec_b, fev_b;
  logic [NA:0]   ec_a;
  logic [NB:0]   ec_b;
  logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;

  logic [1:0]    lat_func;
  logic [7:0]    mask_a, mask_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gate_vector_checker #(.N(NA), .SETTLE(SA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .func(func), .dut_y(y_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(ec_a), .first_err_vec(fev_a)
  );

  gate_vector_checker #(.N(NB), .SETTLE(SB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .func(func), .dut_y(y_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(ec_b), .first_err_vec(fev_b)
  );

  // Ideal gate behaviour expressed arithmetically from the vector's integer value.
  function automatic bit gate_ref(input logic [1:0] f, input int v, input int n);
    case (f)
      2'b01:   return v == 0;
      2'b10:   return (v % 2) == 0;
      default: return v != (1 << n) - 1;
    endcase
  endfunction

  function automatic logic [7:0] stuck_mask(input logic [1:0] f, input bit y, input int n);
    logic [7:0] m = '0;
    for (int v = 0; v < (1 << n); v++) m[v] = (gate_ref(f, v, n) != y);
    return m;
  endfunction

  // Gates under test: correct function flipped on every vector selected by the mask.
  always_comb y_a = gate_ref(lat_func, int'(vec_a), NA) ^ mask_a[vec_a];
  always_comb y_b = gate_ref(lat_func, int'(vec_b), NB) ^ mask_b[vec_b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Whole-sweep outcome from the fault mask: last vector, done cycle, errors, first failure.
  task automatic model(input logic [7:0] m, input int n, input int s,
                       output int last, output int tdone, output int err, output int first);
    err   = 0;
    first = -1;
    for (int v = 0; v < (1 << n); v++) begin
      if (m[v]) begin
        err++;
        if (first < 0) first = v;
      end
    end
    last = (1 << n) - 1;
`ifdef GVC_STOP_ON_ERR_EN
    if (err > 0) begin
      err  = 1;
      last = first;
    end
`endif
    tdone = (last + 1) * (s + 1);
    if (first < 0) first = 0;
  endtask

  task automatic check_cycle(input string id, input int t, input int s, input int last,
                             input int tdone, input int err, input int first,
                             input logic [31:0] v, input logic [31:0] b, input logic [31:0] d,
                             input logic [31:0] p, input logic [31:0] ec, input logic [31:0] fe);
    int ev;
    ev = t / (s + 1);
    if (ev > last) ev = last;
    check({id, ".vec"}, v, ev);
    check({id, ".busy"}, b, (t <= tdone) ? 1 : 0);
    check({id, ".done"}, d, (t == tdone) ? 1 : 0);
    if (t == 0) begin
      check({id, ".pass_clr"}, p, 0);
      check({id, ".err_clr"}, ec, 0);
    end
    if (t >= tdone) begin
      check({id, ".err_count"}, ec, err);
      check({id, ".first_err"}, fe, first);
      check({id, ".pass"}, p, (err == 0) ? 1 : 0);
    end
  endtask

  task automatic run_sweep(input logic [1:0] f, input logic [7:0] ma, input logic [7:0] mb,
                           input int pulse_t, input logic [1:0] f2);
    int la, ta, ea, fa, lb, tb, eb, fb, tmax;
    model(ma, NA, SA, la, ta, ea, fa);
    model(mb, NB, SB, lb, tb, eb, fb);
    tmax = ((ta > tb) ? ta : tb) + 1;
    @(negedge clk);
    mask_a   = ma;
    mask_b   = mb;
    lat_func = f;
    func     = f;
    start    = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= tmax; t++) begin
      @(negedge clk);
      start = (t == pulse_t);
      if (t == pulse_t) func = f2;
      check_cycle("a", t, SA, la, ta, ea, fa, 32'(vec_a), 32'(busy_a), 32'(done_a),
                  32'(pass_a), 32'(ec_a), 32'(fev_a));
      check_cycle("b", t, SB, lb, tb, eb, fb, 32'(vec_b), 32'(busy_b), 32'(done_b),
                  32'(pass_b), 32'(ec_b), 32'(fev_b));
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string id);
    check({id, ".vec_a"}, 32'(vec_a), 0);
    check({id, ".busy_a"}, 32'(busy_a), 0);
    check({id, ".done_a"}, 32'(done_a), 0);
    check({id, ".pass_a"}, 32'(pass_a), 0);
    check({id, ".ec_a"}, 32'(ec_a), 0);
    check({id, ".fev_a"}, 32'(fev_a), 0);
    check({id, ".vec_b"}, 32'(vec_b), 0);
    check({id, ".busy_b"}, 32'(busy_b), 0);
    check({id, ".done_b"}, 32'(done_b), 0);
    check({id, ".ec_b"}, 32'(ec_b), 0);
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk);
    mask_a   = 8'h0;
    mask_b   = 8'h0;
    lat_func = 2'b00;
    func     = 2'b00;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst.vec_a", 32'(vec_a), 2);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ma, mb;
    logic [1:0] f;
    int         pt;
    rst      = 1'b1;
    start    = 1'b0;
    func     = 2'b00;
    lat_func = 2'b00;
    mask_a   = 8'h0;
    mask_b   = 8'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_sweep(2'b00, 8'h0, 8'h0, -1, 2'b00);
    run_sweep(2'b01, stuck_mask(2'b01, 1'b1, NA), stuck_mask(2'b01, 1'b1, NB), -1, 2'b00);
    run_sweep(2'b10, 8'h0, 8'h0, -1, 2'b00);
    run_sweep(2'b00, 8'h0, 8'h0, 3, 2'b01);
    run_sweep(2'b00, stuck_mask(2'b00, 1'b0, NA), stuck_mask(2'b00, 1'b0, NB), -1, 2'b00);
    run_sweep(2'b11, 8'h0, 8'h0, -1, 2'b00);
    reset_mid_sweep();
    run_sweep(2'b00, 8'h0, 8'h0, -1, 2'b00);

    for (int i = 0; i < 12; i++) begin
      f  = 2'($urandom_range(0, 3));
      ma = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom);
      mb = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom);
      pt = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 1));
      run_sweep(f, ma, mb, pt, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Exhaustive truth-table exerciser for the basic CMOS gate experiments (NAND, NOR, NOT, N inputs). It sits directly upstream and downstream of the gate under test. It drives every input vector into the gate, samples the gate output after a settle delay, and compares it with the expected function. At the end of the sweep it reports a mismatch count, the first failing vector and a pass flag.

## Interface
Parameters:
- N, default 2: gate input width (1..8).
- SETTLE, default 1: cycles each vector is held before sampling (1..15).

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: begin a sweep; sampled only in IDLE.
- func  in  2: expected function. 00 = NAND (~&vec), 01 = NOR (~|vec), 10 = NOT (~vec[0]), 11 = reserved and treated as NAND. Latched when start is accepted.
- dut_y  in  1: output of the gate under test.
- vec  out  N: input vector driven to the gate under test.
- busy  out  1: high while a sweep is in progress.
- done  out  1: one-cycle pulse at the end of a sweep.
- pass  out  1: err_count==0 at end of the last sweep; held until the next start is accepted.
- err_count  out  N+1: mismatches in the current or last sweep.
- first_err_vec  out  N: vec value at the first mismatch; 0 if none.

## Operation
- States:
  - IDLE: busy=0.
    - start=1 → DRIVE.
    - On accept: vec=0, settle counter=SETTLE, func latched, err_count=0, first_err_vec=0, pass=0.
  - DRIVE: vec held; counter decrements each cycle.
    - On the cycle the counter reaches 1 → SAMPLE.
  - SAMPLE: dut_y compared with expected(func_latched, vec).
    - On mismatch: err_count+1; first_err_vec=vec if err_count was 0.
    - If vec == all ones → DONE.
    - Otherwise vec+1, counter reloaded to SETTLE → DRIVE.
  - DONE: done=1, busy=1, pass=(err_count==0) registered on entry → IDLE next edge.
- err_count width N+1 holds the maximum of 2^N mismatches; it never wraps or saturates.
- vec holds its last value after the sweep and is cleared only on reset or at the next start.
- start while busy: ignored. func changes while busy: ignored.
- Reset asserted mid-sweep: immediate abort. All outputs return to reset values, no done pulse, state goes to IDLE.
- Reset values: vec=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, state IDLE.

## Timing
- Let start be sampled high at edge k:
  - busy=1 and vec=0 from edge k.
  - vector i is applied from edge k+i(SETTLE+1).
  - vector i is compared at edge k+(i+1)(SETTLE+1).
- DONE is entered at edge k+2^N(SETTLE+1); done is high for exactly that cycle.
- busy falls at the following edge, when the block returns to IDLE.
- start may be re-asserted in the first IDLE cycle after DONE.
- dut_y is treated as combinational from vec. SETTLE covers the gate delay; no internal synchronizer.

## Configuration
- GVC_STOP_ON_ERR_EN defined:
  - a mismatch in SAMPLE goes to DONE instead of advancing.
  - err_count ends at 1, first_err_vec = failing vector, pass=0.
  - vec stays at the failing vector.
- Not defined: the full 2^N sweep always completes, regardless of mismatches.

## Test plan
- N=2, SETTLE=1, func=00, dut_y=~&vec, start at edge k → vec 0,1,2,3 each held 2 cycles; done high after edge k+8; pass=1, err_count=0.
- N=2, SETTLE=1, func=01, dut_y stuck 1 → mismatches at vec 1,2,3; err_count=3, first_err_vec=2'b01, pass=0.
- N=3, SETTLE=2, func=10, dut_y=~vec[0] → vec sweeps 0..7, each held 3 cycles; done after edge k+24; pass=1.
- Pulse start mid-sweep with func switched to 01 (N=2, SETTLE=1, func=00, dut_y=~&vec) → sweep unaffected; done after edge k+8; pass=1 under the original NAND.
- rst asserted while vec=2 → all outputs 0 asynchronously, no done. A following start runs a full sweep from vec=0.
- GVC_STOP_ON_ERR_EN, N=2, SETTLE=1, func=00, dut_y stuck 0 → mismatch at vec=0; done after edge k+2; err_count=1, first_err_vec=0, pass=0.
